// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes, FSM
// encodings and operand-signedness helpers.
package md_sequencer_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [2:0] {
        MdMul    = 3'b000,
        MdMulh   = 3'b001,
        MdMulhsu = 3'b010,
        MdMulhu  = 3'b011,
        MdDiv    = 3'b100,
        MdDivu   = 3'b101,
        MdRem    = 3'b110,
        MdRemu   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdCalc = 2'd1,
        MdDone = 2'd2
    } md_state_e;

    function automatic logic op_is_div(md_op_e op);
        return op[2];
    endfunction

    function automatic logic rs1_is_signed(md_op_e op);
        return (op == MdMul) || (op == MdMulh) || (op == MdMulhsu) ||
               (op == MdDiv) || (op == MdRem);
    endfunction

    // mulhsu reads rs2 as unsigned
    function automatic logic rs2_is_signed(md_op_e op);
        return (op == MdMul) || (op == MdMulh) || (op == MdDiv) || (op == MdRem);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer signal bundle.
interface md_sequencer_if
    import md_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);
    logic            start_EX;
    logic [2:0]      md_op_EX;
    logic [XLEN-1:0] rs1_val_EX;
    logic [XLEN-1:0] rs2_val_EX;
    logic            flush_EX;
    logic            stall_pipe;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start_EX, md_op_EX, rs1_val_EX, rs2_val_EX, flush_EX,
        input  stall_pipe, busy, result_valid, result
    );

    modport slave (
        input  start_EX, md_op_EX, rs1_val_EX, rs2_val_EX, flush_EX,
        output stall_pipe, busy, result_valid, result
    );
endinterface

// File: rtl/md_iter_datapath.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Pure next-value logic; the caller owns every register.
module md_iter_datapath #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next,
    output logic [XLEN-1:0]   opb_next
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] rem_sub;
    logic            q_bit;

    // Divide: opb shifts the dividend out at the top while quotient bits enter
    // at the bottom; acc[XLEN-1:0] holds the partial remainder.
    always_comb begin
        rem_sh   = {acc[XLEN-1:0], opb[XLEN-1]};
        rem_sub  = {1'b0, rem_sh} - {2'b00, opa};
        q_bit    = ~rem_sub[XLEN+1];
        acc_next = acc;
        opb_next = opb;
        if (is_div) begin
            acc_next = {{XLEN{1'b0}}, (q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0])};
            opb_next = {opb[XLEN-2:0], q_bit};
        end else begin
            acc_next = {acc[2*XLEN-2:0], 1'b0} +
                       (opb[XLEN-1] ? {{XLEN{1'b0}}, opa} : {(2*XLEN){1'b0}});
            opb_next = {opb[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage: stalls the
// pipeline for XLEN iterations (or one cycle on a fast path) and posts the result.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input logic          clk,
    input logic          rst,
    md_sequencer_if.slave md
);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign1_q, sign1_d, sign2_q, sign2_d;
    logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    md_op_e            op_in;
    logic              s1, s2, div_zero, ovf, fast, is_div_q, last_iter, stall;
    logic [XLEN-1:0]   abs1, abs2, fast_res, calc_res, quot, rem, opb_nx;
    logic [2*XLEN-1:0] acc_nx, prod;

    assign op_in    = md_op_e'(md.md_op_EX);
    assign s1       = rs1_is_signed(op_in) & md.rs1_val_EX[XLEN-1];
    assign s2       = rs2_is_signed(op_in) & md.rs2_val_EX[XLEN-1];
    assign abs1     = s1 ? -md.rs1_val_EX : md.rs1_val_EX;
    assign abs2     = s2 ? -md.rs2_val_EX : md.rs2_val_EX;
    assign div_zero = op_is_div(op_in) && (md.rs2_val_EX == '0);
    assign ovf      = ((op_in == MdDiv) || (op_in == MdRem)) &&
                      (md.rs1_val_EX == {1'b1, {(XLEN-1){1'b0}}}) && (md.rs2_val_EX == '1);
    assign fast     = div_zero | ovf;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = op_in[1] ? md.rs1_val_EX : '1;
        end else if (op_in == MdDiv) begin
            fast_res = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    assign is_div_q  = op_is_div(op_q);
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    md_iter_datapath #(
        .XLEN(XLEN)
    ) u_iter (
        .acc      (acc_q),
        .opa      (opa_q),
        .opb      (opb_q),
        .is_div   (is_div_q),
        .acc_next (acc_nx),
        .opb_next (opb_nx)
    );

    // Sign fixup of the final iteration's value, taken on the CALC->DONE edge
    assign prod = (sign1_q ^ sign2_q) ? -acc_nx : acc_nx;
    assign quot = (sign1_q ^ sign2_q) ? -opb_nx : opb_nx;
    assign rem  = sign1_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];

    always_comb begin
        calc_res = '0;
        unique case (op_q)
            MdMul:                      calc_res = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu:  calc_res = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:              calc_res = quot;
            MdRem, MdRemu:              calc_res = rem;
            default:                    calc_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        stall    = 1'b0;
        unique case (state_q)
            MdIdle: begin
                if (md.start_EX && !md.flush_EX) begin
                    stall   = 1'b1;
                    op_d    = op_in;
                    sign1_d = s1;
                    sign2_d = s2;
                    opa_d   = abs2;
                    opb_d   = abs1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (fast) begin
                        result_d = fast_res;
                        state_d  = MdDone;
                    end else begin
                        state_d  = MdCalc;
                    end
                end
            end
            MdCalc: begin
                if (md.flush_EX) begin
                    state_d = MdIdle;
                end else begin
                    stall = 1'b1;
                    acc_d = acc_nx;
                    opb_d = opb_nx;
                    cnt_d = (cnt_q == CNT_W'(XLEN)) ? cnt_q : cnt_q + 1'b1;
                    if (last_iter) begin
                        result_d = calc_res;
                        state_d  = MdDone;
                    end
                end
            end
            MdDone:  state_d = MdIdle;
            default: state_d = MdIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MdIdle;
            op_q     <= MdMul;
            cnt_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign md.stall_pipe   = stall & ~rst;
    assign md.busy         = (state_q != MdIdle);
    assign md.result_valid = (state_q == MdDone);
    assign md.result       = result_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed RV32M vectors, fast paths, flush,
// back-to-back start and asynchronous reset.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    md_sequencer_if #(.XLEN(32)) bus ();

    md_sequencer dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every result_valid pops one expectation (value and cycle).
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result %08h at cycle %0d, expected none",
                         bus.result, cyc);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_val"}, bus.result, e.val);
                check({e.name, "_cyc"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one op, then count stall cycles until the sequencer is idle again.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        bit done;
        @(posedge clk); #1;
        bus.start_EX   = 1'b1;
        bus.md_op_EX   = op;
        bus.rs1_val_EX = a;
        bus.rs2_val_EX = b;
        sb_q.push_back('{val: exp, cyc: cyc + lat, name: name});
        @(negedge clk);
        n = bus.stall_pipe ? 1 : 0;
        @(posedge clk); #1;
        bus.start_EX = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.stall_pipe) n++;
            if (!bus.busy) done = 1'b1;
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(lat));
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still %0b after 40 cycles, expected 0", name, bus.busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_EX   = 1'b0;
        bus.md_op_EX   = 3'b000;
        bus.rs1_val_EX = '0;
        bus.rs2_val_EX = '0;
        bus.flush_EX   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        bus.start_EX = 1'b1;
        #1;
        check("rst_stall", 32'(bus.stall_pipe), 32'd0);
        bus.start_EX = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_op("mulhu_max",  MdMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mul_neg",    MdMul,    32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 33);
        do_op("mulh_neg",   MdMulh,   32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 33);
        do_op("mulhsu",     MdMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("div_neg",    MdDiv,    32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
        do_op("rem_neg",    MdRem,    32'd20,        32'hFFFF_FFFD, 32'd2,         33);
        do_op("divu",       MdDivu,   32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33);
        do_op("remu",       MdRemu,   32'd7,         32'd3,         32'd1,         33);
        do_op("div_zero",   MdDiv,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("rem_zero",   MdRem,    32'd5,         32'd0,         32'd5,         1);
        do_op("div_ovf",    MdDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",    MdRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        do_op("remu_again", MdRemu,   32'd7,         32'd3,         32'd1,         33);

        // Flush in cycle 10 of a divu: no result, previous result held.
        @(posedge clk); #1;
        bus.start_EX   = 1'b1;
        bus.md_op_EX   = MdDivu;
        bus.rs1_val_EX = 32'd100;
        bus.rs2_val_EX = 32'd7;
        @(posedge clk); #1;
        bus.start_EX = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush_EX = 1'b1;
        @(negedge clk);
        check("flush_stall_c10", 32'(bus.stall_pipe), 32'd0);
        check("flush_busy_c10", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.flush_EX = 1'b0;
        @(negedge clk);
        check("flush_idle_c11", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_result_held", bus.result, 32'd1);

        // start together with flush is not accepted.
        @(posedge clk); #1;
        bus.start_EX = 1'b1;
        bus.flush_EX = 1'b1;
        bus.md_op_EX = MdMul;
        @(negedge clk);
        check("startflush_stall", 32'(bus.stall_pipe), 32'd0);
        @(posedge clk); #1;
        bus.start_EX = 1'b0;
        bus.flush_EX = 1'b0;
        @(negedge clk);
        check("startflush_busy", 32'(bus.busy), 32'd0);

        // start held through DONE is ignored; a new op right after DONE is taken.
        @(posedge clk); #1;
        bus.start_EX   = 1'b1;
        bus.md_op_EX   = MdMul;
        bus.rs1_val_EX = 32'd3;
        bus.rs2_val_EX = 32'd5;
        sb_q.push_back('{val: 32'd15, cyc: cyc + 33, name: "hold_mul"});
        repeat (33) @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_done_stall", 32'(bus.stall_pipe), 32'd0);
        @(posedge clk); #1;
        bus.md_op_EX   = MdDiv;
        bus.rs1_val_EX = 32'd5;
        bus.rs2_val_EX = 32'd0;
        sb_q.push_back('{val: 32'hFFFF_FFFF, cyc: cyc + 1, name: "b2b_div"});
        @(negedge clk);
        check("b2b_accept_stall", 32'(bus.stall_pipe), 32'd1);
        @(posedge clk); #1;
        bus.start_EX = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in cycle 15 of a mul.
        @(posedge clk); #1;
        bus.start_EX   = 1'b1;
        bus.md_op_EX   = MdMul;
        bus.rs1_val_EX = 32'd3;
        bus.rs2_val_EX = 32'd5;
        @(posedge clk); #1;
        bus.start_EX = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_stall", 32'(bus.stall_pipe), 32'd0);
        check("arst_result", bus.result, 32'd0);
        check("arst_valid", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
